// File: rtl/gpio_dec_display.sv
// Converts a 32-bit GPIO value into eight seven-segment digits. The conversion
// uses iterative double-dabble; the displays update only when a conversion completes.
module gpio_dec_display #(
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] value_in,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;

  localparam logic [6:0] SEG_ZERO  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [1:0]  state;
  logic [31:0] captured;
  logic [31:0] bin;
  logic [39:0] bcd;
  logic [4:0]  count;
  logic [6:0]  hex_q [NUM_DIGITS];

  logic [39:0] bcd_adj;
  logic [6:0]  hex_d [NUM_DIGITS];
  logic        over_d;
  logic        seen;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction applied to every digit ahead of each one-bit shift.
  always_comb begin
    // NOTE: default assignment first so no path leaves bcd_adj unassigned (no latch).
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the top digit down; once a nonzero digit is seen, everything below is shown.
  always_comb begin
    over_d = |bcd[39:32];
    seen   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen = seen | (bcd[4*i +: 4] != 4'd0) | (i == 0);
      if (over_d)    hex_d[i] = SEG_DASH;
      else if (seen) hex_d[i] = seg(bcd[4*i +: 4]);
      else           hex_d[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    if (res) begin
      state    <= IDLE;
      captured <= '0;
      bin      <= '0;
      bcd      <= '0;
      count    <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (value_in != captured) begin
            captured <= value_in;
            bin      <= value_in;
            bcd      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          count      <= count + 5'd1;
          if (count == 5'd31) state <= UPDATE;
        end
        UPDATE: begin
          for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= hex_d[i];
          overflow <= over_d;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule

// File: tb/tb_gpio_dec_display.sv
// Self-checking bench for gpio_dec_display: directed scenarios plus random values
// compared against a decimal-arithmetic reference of the expected display.
module tb_gpio_dec_display;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] value_in;
  logic        busy;
  logic        overflow;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  gpio_dec_display #(.NUM_DIGITS(8)) dut (
    .clk(clk), .res(res), .value_in(value_in), .busy(busy), .overflow(overflow),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle, so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] get_hex(input int i);
    case (i)
      0: return hex0;
      1: return hex1;
      2: return hex2;
      3: return hex3;
      4: return hex4;
      5: return hex5;
      6: return hex6;
      default: return hex7;
    endcase
  endfunction

  // Reference: plain decimal arithmetic on the value.
  function automatic logic [6:0] exp_hex(input logic [31:0] v, input int i);
    longint p = 1;
    longint lv = longint'(v);
    for (int k = 0; k < i; k++) p = p * 10;
    if (lv >= 100_000_000) return 7'h3F;
    if (i > 0 && lv < p) return 7'h7F;
    return seg_tab[int'((lv / p) % 10)];
  endfunction

  task automatic check_display(input string tag, input logic [31:0] v);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_hex%0d", tag, i), 32'(get_hex(i)), 32'(exp_hex(v, i)));
    check({tag, "_ovf"}, 32'(overflow), (longint'(v) >= 100_000_000) ? 32'd1 : 32'd0);
  endtask

  // Apply a new value from IDLE and follow the conversion; checks latency,
  // busy duration, that displays hold until the update edge, and the result.
  task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] prev);
    int edges = 0;
    int busy_cycles = 0;
    int held_bad = 0;
    value_in = v;
    do begin
      step();
      edges++;
      if (busy) begin
        busy_cycles++;
        for (int i = 0; i < 8; i++) if (get_hex(i) !== exp_hex(prev, i)) held_bad++;
      end
    end while (busy && edges < 100);
    check({tag, "_latency"}, edges, 34);
    check({tag, "_busy_cycles"}, busy_cycles, 33);
    check({tag, "_hold"}, held_bad, 0);
    check_display(tag, v);
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] v;
    int bad;
    int edges;

    // Reset and idle with value 0.
    res = 1'b1;
    value_in = 32'd0;
    step();
    step();
    res = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (busy !== 1'b0 || overflow !== 1'b0 || hex0 !== 7'h40 || hex1 !== 7'h7F ||
          hex7 !== 7'h7F) bad++;
    end
    check("reset_idle_bad_cycles", bad, 0);
    check_display("reset", 32'd0);
    cur = 32'd0;

    convert("basic_1234", 32'd1234, cur);
    cur = 32'd1234;
    convert("max_99999999", 32'd99_999_999, cur);
    cur = 32'd99_999_999;
    convert("ovf_100000000", 32'd100_000_000, cur);
    cur = 32'd100_000_000;
    convert("full_ffffffff", 32'hFFFF_FFFF, cur);
    cur = 32'hFFFF_FFFF;
    convert("back_to_zero", 32'd0, cur);
    cur = 32'd0;

    // Same value again: no conversion should start.
    step();
    check("no_change_busy", 32'(busy), 32'd0);

    // Mid-conversion change: 5 then 7 after ten edges.
    value_in = 32'd5;
    for (int c = 0; c < 10; c++) step();
    value_in = 32'd7;
    edges = 10;
    while (busy && edges < 100) begin step(); edges++; end
    check("mid_first_latency", edges, 34);
    check_display("mid_first_5", 32'd5);
    edges = 0;
    do begin step(); edges++; end while (!busy && edges < 5);
    check("mid_restart_edges", edges, 1);
    edges = 0;
    while (busy && edges < 100) begin
      step();
      edges++;
      if (busy) check("mid_no_garbage", 32'(hex0), 32'h12);
    end
    check_display("mid_second_7", 32'd7);
    cur = 32'd7;

    // Reset at SHIFT count 15, then a fresh conversion of the same value.
    value_in = 32'd42;
    for (int c = 0; c < 16; c++) step();
    check("rstmid_busy_before", 32'(busy), 32'd1);
    res = 1'b1;
    step();
    res = 1'b0;
    check("rstmid_busy_after", 32'(busy), 32'd0);
    check_display("rstmid_reset", 32'd0);
    convert("rstmid_42", 32'd42, 32'd0);
    cur = 32'd42;

    // Random values across several ranges.
    for (int r = 0; r < 24; r++) begin
      case (r % 4)
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        2: v = $urandom_range(0, 99_999_999);
        default: v = $urandom_range(90_000_000, 110_000_000);
      endcase
      if (v == cur) v = v + 32'd1;
      convert($sformatf("rand%0d", r), v, cur);
      cur = v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
